// File: rtl/sprite_scan_buffer_pkg.sv
// Shared PPU types for the sprite scanline search: FSM states, buffer entry
// layout, the OAM base address and sprite heights.
package ppu_pkg;
  typedef enum logic [1:0] {IDLE, REQ_Y, REQ_X, DONE} scan_state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [5:0] oam_idx;
    logic [3:0] row;
  } sprite_entry_t;

  localparam logic [15:0] PPU_OAM_BASE = 16'hFE00;
  localparam int          SPR_H_SHORT  = 8;
  localparam int          SPR_H_TALL   = 16;

  // Each OAM entry is 4 bytes: Y at +0, X at +1.
  function automatic logic [15:0] oam_addr(input logic [15:0] base,
                                           input logic [5:0]  idx,
                                           input logic        ofs);
    return base + {8'h00, idx, 2'b00} + {15'h0000, ofs};
  endfunction
endpackage

// File: rtl/sprite_scan_buffer_if.sv
// OAM read port: the scanner issues held requests, memory answers with a
// data byte and a one-cycle valid strobe.
interface sprite_scan_buffer_if;
  logic        oam_req_out;
  logic [15:0] oam_addr_out;
  logic [7:0]  oam_data_in;
  logic        oam_valid_in;

  modport master (output oam_req_out, output oam_addr_out,
                  input  oam_data_in, input  oam_valid_in);
  modport slave  (input  oam_req_out, input  oam_addr_out,
                  output oam_data_in, output oam_valid_in);
endinterface

// File: rtl/sprite_scan_buffer_y_match.sv
// Combinational Y range test for one sprite against the current scanline.
module sprite_y_match
  import ppu_pkg::*;
#(
  parameter int Y_OFFSET = 16
) (
  input  logic [7:0] ly_in,
  input  logic       tall_in,
  input  logic [7:0] y_in,
  output logic       hit_out,
  output logic [3:0] row_out
);
  logic [8:0] w_l, w_y, w_top;

  // 9-bit math so sprites near the bottom never wrap back onto line 0.
  assign w_l     = {1'b0, ly_in} + 9'(Y_OFFSET);
  assign w_y     = {1'b0, y_in};
  assign w_top   = w_y + (tall_in ? 9'(SPR_H_TALL) : 9'(SPR_H_SHORT));
  assign hit_out = (w_l >= w_y) && (w_l < w_top);
  assign row_out = 4'(w_l - w_y);
endmodule

// File: rtl/sprite_scan_buffer.sv
// Per-scanline OAM search: walks every sprite, keeps the first BUFFER_DEPTH
// that cover LY in OAM order, and flags overflow if more were found.
module sprite_scan_buffer
  import ppu_pkg::*;
#(
  parameter int          NUM_SPRITES  = 40,
  parameter int          BUFFER_DEPTH = 10,
  parameter int          Y_OFFSET     = 16,
  parameter logic [15:0] OAM_BASE     = PPU_OAM_BASE
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  input  logic [7:0]                        LY_in,
  input  logic                              tall_in,
  input  logic                              obj_en_in,
  sprite_scan_buffer_if.master              oam,
  input  logic [$clog2(BUFFER_DEPTH)-1:0]   rd_idx_in,
  output logic [17:0]                       rd_entry_out,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0] count_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              overflow_out
);
  localparam int RIW = $clog2(BUFFER_DEPTH);
  localparam int CW  = $clog2(BUFFER_DEPTH+1);

  scan_state_e   r_state;
  logic [5:0]    r_i;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_busy, r_done, r_req, r_tall;
  logic [15:0]   r_addr;
  logic [7:0]    r_ly;
  logic [3:0]    r_row;
  sprite_entry_t r_buf [BUFFER_DEPTH];
  sprite_entry_t r_rd;

  logic       w_hit, w_last, w_full;
  logic [3:0] w_row;

  sprite_y_match #(.Y_OFFSET(Y_OFFSET)) u_ymatch (
    .ly_in  (r_ly),
    .tall_in(r_tall),
    .y_in   (oam.oam_data_in),
    .hit_out(w_hit),
    .row_out(w_row)
  );

  assign w_last = (r_i == 6'(NUM_SPRITES-1));
  assign w_full = (r_count == CW'(BUFFER_DEPTH));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_ly    <= '0;
      r_tall  <= 1'b0;
      r_row   <= '0;
      r_rd    <= '0;
      for (int k = 0; k < BUFFER_DEPTH; k++) r_buf[k] <= '0;
    end else begin
      // Stale slots beyond count stay in the array but never reach the port.
      r_rd <= (32'(rd_idx_in) < 32'(r_count)) ? r_buf[rd_idx_in] : '0;

      if (start_in) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_i     <= '0;
        r_ly    <= LY_in;
        r_tall  <= tall_in;
        r_addr  <= oam_addr(OAM_BASE, 6'd0, 1'b0);
        if (obj_en_in) begin
          r_state <= REQ_Y;
          r_req   <= 1'b1;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end else begin
          r_state <= DONE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else begin
        case (r_state)
          REQ_Y: if (oam.oam_valid_in) begin
            if (w_hit) begin
              r_row   <= w_row;
              r_addr  <= oam_addr(OAM_BASE, r_i, 1'b1);
              r_state <= REQ_X;
            end else if (w_last) begin
              r_state <= DONE;
              r_req   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_i    <= r_i + 6'd1;
              r_addr <= oam_addr(OAM_BASE, r_i + 6'd1, 1'b0);
            end
          end
          REQ_X: if (oam.oam_valid_in) begin
            // X=0 is kept: culling off-screen sprites happens downstream.
            if (!w_full) begin
              r_buf[RIW'(r_count)] <= '{x: oam.oam_data_in, oam_idx: r_i, row: r_row};
              r_count              <= r_count + CW'(1);
            end else begin
              r_ovf <= 1'b1;
            end
            if (w_last) begin
              r_state <= DONE;
              r_req   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_i     <= r_i + 6'd1;
              r_addr  <= oam_addr(OAM_BASE, r_i + 6'd1, 1'b0);
              r_state <= REQ_Y;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign oam.oam_req_out  = r_req;
  assign oam.oam_addr_out = r_addr;
  assign rd_entry_out     = r_rd;
  assign count_out        = r_count;
  assign busy_out         = r_busy;
  assign done_out         = r_done;
  assign overflow_out     = r_ovf;
endmodule

// File: tb/tb_sprite_scan_buffer.sv
// Directed bench for sprite_scan_buffer with an OAM memory model, a
// configurable-latency responder and an expected-entry scoreboard.
module tb_sprite_scan_buffer;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, tall = 1'b0, en = 1'b0;
  logic [7:0]  ly = 8'd0;
  logic [3:0]  rd_idx = 4'd0;
  logic [17:0] rd_entry;
  logic [3:0]  count;
  logic        busy, done, ovf;

  logic [7:0]  mem [256];
  int          delay = 0;
  logic        early = 1'b0;
  int          wcnt = 0, xreads = 0, unstable = 0;
  logic        pend = 1'b0;
  logic [15:0] prev = 16'h0;
  int          total = 0, bad = 0;
  logic [17:0] exp_q [$];

  sprite_scan_buffer_if bus();

  sprite_scan_buffer dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .LY_in(ly),
    .tall_in(tall), .obj_en_in(en), .oam(bus), .rd_idx_in(rd_idx),
    .rd_entry_out(rd_entry), .count_out(count), .busy_out(busy),
    .done_out(done), .overflow_out(ovf)
  );

  always #5 clk = ~clk;

  assign bus.oam_valid_in = (bus.oam_req_out && (wcnt >= delay)) || early;
  assign bus.oam_data_in  = mem[bus.oam_addr_out[7:0]];

  // Responder bookkeeping: read latency, X read count, address stability.
  always @(posedge clk) begin
    if (bus.oam_req_out && bus.oam_valid_in) begin
      wcnt <= 0;
      if (bus.oam_addr_out[1:0] == 2'd1) xreads <= xreads + 1;
    end else if (bus.oam_req_out) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (pend && bus.oam_req_out && bus.oam_addr_out != prev) unstable <= unstable + 1;
    pend <= bus.oam_req_out && !bus.oam_valid_in;
    prev <= bus.oam_addr_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ent(input int x, input int idx, input int row);
    return {8'(x), 6'(idx), 4'(row)};
  endfunction

  task automatic clr_mem();
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
  endtask

  task automatic set_spr(input int i, input int y, input int x);
    mem[4*i]   = 8'(y);
    mem[4*i+1] = 8'(x);
  endtask

  task automatic start_scan(input int l, input logic t, input logic e);
    @(negedge clk);
    ly = 8'(l); tall = t; en = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic rd(input int k, output logic [17:0] e);
    @(negedge clk);
    rd_idx = 4'(k);
    @(posedge clk); #1;
    e = rd_entry;
  endtask

  task automatic check_entries(input string tag, input int n);
    logic [17:0] e;
    for (int k = 0; k < n; k++) begin
      rd(k, e);
      if (exp_q.size() == 0) chk({tag, "_qempty"}, 32'(e), 32'hFFFFFFFF);
      else chk(tag, 32'(e), 32'(exp_q.pop_front()));
    end
    rd(n, e);
    chk({tag, "_beyond"}, 32'(e), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, x0, u0;
    logic [17:0] e;
    clr_mem();
    #3 rst_n = 1'b0;
    #20;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req",   32'(bus.oam_req_out), 32'd0);
    chk("rst_addr",  32'(bus.oam_addr_out), 32'd0);
    chk("rst_entry", 32'(rd_entry), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Stray valid strobes while idle must not start anything.
    @(negedge clk) early = 1'b1;
    @(negedge clk); @(negedge clk) early = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_req",  32'(bus.oam_req_out), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_cnt",  32'(count), 32'd0);

    // Single hit on line 0.
    clr_mem(); set_spr(3, 16, 8);
    exp_q.push_back(ent(8, 3, 0));
    x0 = xreads;
    start_scan(0, 1'b0, 1'b1);
    wait_done(n);
    chk("one_cycles", 32'(n), 32'd41);
    chk("one_count",  32'(count), 32'd1);
    chk("one_ovf",    32'(ovf), 32'd0);
    chk("one_busy",   32'(busy), 32'd0);
    chk("one_xreads", 32'(xreads - x0), 32'd1);
    check_entries("one_ent", 1);

    // Twelve hits: ten kept, overflow flagged, scan runs to the end.
    clr_mem();
    for (int i = 0; i < 12; i++) set_spr(i, 66, i + 1);
    for (int i = 0; i < 10; i++) exp_q.push_back(ent(i + 1, i, 0));
    x0 = xreads;
    start_scan(50, 1'b0, 1'b1);
    wait_done(n);
    chk("ovf_cycles", 32'(n), 32'd52);
    chk("ovf_count",  32'(count), 32'd10);
    chk("ovf_flag",   32'(ovf), 32'd1);
    chk("ovf_xreads", 32'(xreads - x0), 32'd12);
    check_entries("ovf_ent", 10);

    // Tall sprite hit (row 10, X=0 kept), then the same line in 8x8 mode misses.
    clr_mem(); set_spr(0, 16, 0);
    exp_q.push_back(ent(0, 0, 10));
    start_scan(10, 1'b1, 1'b1);
    wait_done(n);
    chk("tall_count", 32'(count), 32'd1);
    check_entries("tall_ent", 1);
    x0 = xreads;
    start_scan(10, 1'b0, 1'b1);
    wait_done(n);
    chk("short_count",  32'(count), 32'd0);
    chk("short_xreads", 32'(xreads - x0), 32'd0);
    chk("short_cycles", 32'(n), 32'd40);

    // Bottom-of-range boundaries.
    clr_mem(); set_spr(0, 159, 77);
    exp_q.push_back(ent(77, 0, 0));
    start_scan(143, 1'b0, 1'b1);
    wait_done(n);
    chk("edge_count", 32'(count), 32'd1);
    check_entries("edge_ent", 1);
    set_spr(0, 160, 77);
    start_scan(143, 1'b0, 1'b1);
    wait_done(n);
    chk("edge_miss_count", 32'(count), 32'd0);
    set_spr(0, 255, 9);
    exp_q.push_back(ent(9, 0, 11));
    start_scan(250, 1'b1, 1'b1);
    wait_done(n);
    chk("wrap_count", 32'(count), 32'd1);
    check_entries("wrap_ent", 1);

    // Sprites disabled: straight to done.
    start_scan(0, 1'b0, 1'b0);
    chk("dis_done",  32'(done), 32'd1);
    chk("dis_busy",  32'(busy), 32'd0);
    chk("dis_count", 32'(count), 32'd0);
    chk("dis_req",   32'(bus.oam_req_out), 32'd0);

    // Slow memory: every read waits three cycles, address must hold.
    delay = 3;
    clr_mem(); set_spr(3, 16, 8);
    exp_q.push_back(ent(8, 3, 0));
    u0 = unstable;
    start_scan(0, 1'b0, 1'b1);
    wait_done(n);
    chk("slow_cycles",   32'(n), 32'd164);
    chk("slow_count",    32'(count), 32'd1);
    chk("slow_unstable", 32'(unstable - u0), 32'd0);
    check_entries("slow_ent", 1);
    delay = 0;

    // Restart mid-scan at sprite 20.
    clr_mem();
    for (int i = 0; i < 4; i++) set_spr(i, 16, i + 10);
    set_spr(30, 16, 99);
    start_scan(0, 1'b0, 1'b1);
    for (int k = 0; k < 200 && !(bus.oam_req_out && bus.oam_addr_out == 16'hFE50); k++)
      @(negedge clk);
    chk("rs_reached", 32'(bus.oam_addr_out), 32'hFE50);
    chk("rs_pre_count", 32'(count), 32'd4);
    start = 1'b1;
    @(posedge clk); #1;
    chk("rs_count", 32'(count), 32'd0);
    chk("rs_addr",  32'(bus.oam_addr_out), 32'hFE00);
    chk("rs_busy",  32'(busy), 32'd1);
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(i + 10, i, 0));
    exp_q.push_back(ent(99, 30, 0));
    wait_done(n);
    chk("rs_final_count", 32'(count), 32'd5);
    chk("rs_ovf", 32'(ovf), 32'd0);
    check_entries("rs_ent", 5);

    // Async reset while waiting in an X read.
    delay = 3;
    clr_mem(); set_spr(0, 16, 5); set_spr(2, 16, 6);
    @(negedge clk) rd_idx = 4'd0;
    start_scan(0, 1'b0, 1'b1);
    for (int k = 0; k < 200 && !(bus.oam_req_out && bus.oam_addr_out == 16'hFE09); k++)
      @(negedge clk);
    chk("ar_reached", 32'(bus.oam_addr_out), 32'hFE09);
    chk("ar_pre_count", 32'(count), 32'd1);
    chk("ar_pre_entry", 32'(rd_entry), 32'(ent(5, 0, 0)));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_req",   32'(bus.oam_req_out), 32'd0);
    chk("ar_addr",  32'(bus.oam_addr_out), 32'd0);
    chk("ar_entry", 32'(rd_entry), 32'd0);
    chk("ar_busy",  32'(busy), 32'd0);
    chk("ar_done",  32'(done), 32'd0);
    chk("ar_ovf",   32'(ovf), 32'd0);
    delay = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_req", 32'(bus.oam_req_out), 32'd0);
    chk("post_rst_q",   32'(exp_q.size()), 32'd0);
    rd(0, e);
    chk("post_rst_entry", 32'(e), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
